// File: rtl/piece_fall_ctrl.sv
// Active-piece controller: loads the spawned board from clear_redraw, applies gravity
// and lateral moves to the piece, and on landing emits a lock pulse plus the next piece type.
module piece_fall_ctrl #(
  parameter int DROP_DIV  = 8,
  parameter int CLEAR_LAT = 2
) (
  input  logic        clka,
  input  logic        restart,
  input  logic        start,
  input  logic [31:0] board_in,
  input  logic        error_in,
  input  logic        move_left,
  input  logic        move_right,
  input  logic        soft_drop,
  output logic [31:0] board_out,
  output logic [31:0] piece_mask,
  output logic        lock_valid,
  output logic [1:0]  next_piece,
  output logic        game_over
);

  localparam int CNT_MAX = (DROP_DIV > CLEAR_LAT) ? DROP_DIV : CLEAR_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, LOCK, WAIT, LOAD, FALL, OVER} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       lfsr;
  logic [31:0]      locked;

  logic [31:0] down, left, right, spawn;
  logic [3:0]  lfsr_next;
  logic        land, left_ok, right_ok, step;

  function automatic logic [31:0] spawn_mask(input logic [1:0] kind);
    case (kind)
      2'b00:   return 32'h0000_0002;
      2'b01:   return 32'h0000_0006;
      2'b10:   return 32'h0000_0066;
      default: return 32'h0000_0062;
    endcase
  endfunction

  // Candidate piece positions; moves are rejected at the board edge so nothing wraps across rows.
  assign down      = piece_mask << 4;
  assign left      = piece_mask << 1;
  assign right     = piece_mask >> 1;
  assign land      = (|piece_mask[31:28]) || (|(down & locked));
  assign left_ok   = !(|(piece_mask & 32'h8888_8888)) && !(|(left & locked));
  assign right_ok  = !(|(piece_mask & 32'h1111_1111)) && !(|(right & locked));
  assign step      = (cnt == CNT_W'(DROP_DIV - 1)) || soft_drop;
  assign lfsr_next = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  assign spawn     = spawn_mask(next_piece);

  always_ff @(posedge clka) begin
    if (restart) begin
      state      <= IDLE;
      cnt        <= '0;
      lfsr       <= 4'b1001;
      locked     <= '0;
      board_out  <= '0;
      piece_mask <= '0;
      lock_valid <= 1'b0;
      next_piece <= 2'b00;
      game_over  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOCK;
            board_out  <= '0;
            lock_valid <= 1'b1;
            lfsr       <= lfsr_next;
            next_piece <= lfsr_next[1:0];
          end
        end
        LOCK: begin
          lock_valid <= 1'b0;
          piece_mask <= '0;
          cnt        <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_W'(CLEAR_LAT - 1)) begin
            cnt   <= '0;
            state <= LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LOAD: begin
          locked     <= board_in & ~spawn;
          piece_mask <= spawn;
          board_out  <= board_in;
          cnt        <= '0;
          if (error_in) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else begin
            state <= FALL;
          end
        end
        FALL: begin
          board_out <= locked | piece_mask;
          if (step) begin
            cnt <= '0;
            if (land) begin
              state      <= LOCK;
              lock_valid <= 1'b1;
              lfsr       <= lfsr_next;
              next_piece <= lfsr_next[1:0];
            end else begin
              piece_mask <= down;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (move_left && !move_right && left_ok)
              piece_mask <= left;
            else if (move_right && !move_left && right_ok)
              piece_mask <= right;
          end
        end
        OVER: begin
          lock_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_fall_ctrl.sv
// Self-checking bench for piece_fall_ctrl: scoreboard queue of expected outputs plus
// a move-vector table and hand-written gravity, collision, game-over and restart sequences.
module tb_piece_fall_ctrl;

  localparam int DROP_DIV  = 8;
  localparam int CLEAR_LAT = 2;

  logic        clka = 1'b0;
  logic        restart, start, error_in, move_left, move_right, soft_drop;
  logic [31:0] board_in;
  logic [31:0] board_out, piece_mask;
  logic        lock_valid, game_over;
  logic [1:0]  next_piece;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic        ml;
    logic        mr;
    logic [31:0] exp_mask;
  } vec_t;
  vec_t vt[6];

  piece_fall_ctrl #(.DROP_DIV(DROP_DIV), .CLEAR_LAT(CLEAR_LAT)) dut (
    .clka       (clka),
    .restart    (restart),
    .start      (start),
    .board_in   (board_in),
    .error_in   (error_in),
    .move_left  (move_left),
    .move_right (move_right),
    .soft_drop  (soft_drop),
    .board_out  (board_out),
    .piece_mask (piece_mask),
    .lock_valid (lock_valid),
    .next_piece (next_piece),
    .game_over  (game_over)
  );

  always #5 clka = ~clka;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic push(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:       return board_out;
      1:       return piece_mask;
      2:       return {31'b0, lock_valid};
      3:       return {30'b0, next_piece};
      default: return {31'b0, game_over};
    endcase
  endfunction

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      compare(e.name, actual(e.sel), e.val);
    end
  endtask

  task automatic wait_lock(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (lock_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL lock_timeout: no lock_valid within %0d cycles", budget);
    end
  endtask

  // Called on the cycle lock_valid is seen; returns right after the LOAD edge.
  task automatic load_after_lock(input logic [31:0] b, input logic err);
    board_in = b;
    error_in = err;
    tick();
    push("lock_single_cycle", 2, 0);
    drain();
    for (int i = 0; i < CLEAR_LAT + 1; i++) tick();
    error_in = 1'b0;
  endtask

  task automatic reach_type10();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    push("start_lock", 2, 1);
    push("start_board", 0, 32'h0);
    push("start_next", 3, 32'd3);
    drain();
    load_after_lock(32'h0000_0062, 1'b0);
    push("load62_mask", 1, 32'h0000_0062);
    drain();
    soft_drop = 1'b1;
    wait_lock(20);
    soft_drop = 1'b0;
    push("drop62_board", 0, 32'h6200_0000);
    push("drop62_next", 3, 32'd2);
    drain();
  endtask

  initial begin
    int locks;
    vt[0] = '{1'b1, 1'b0, 32'h0000_00CC};
    vt[1] = '{1'b1, 1'b0, 32'h0000_00CC};
    vt[2] = '{1'b1, 1'b1, 32'h0000_00CC};
    vt[3] = '{1'b0, 1'b1, 32'h0000_0066};
    vt[4] = '{1'b0, 1'b1, 32'h0000_0033};
    vt[5] = '{1'b0, 1'b1, 32'h0000_0033};

    // Restart beats start and moves held at the same time.
    restart = 1'b1; start = 1'b1; move_left = 1'b1; move_right = 1'b0;
    soft_drop = 1'b1; error_in = 1'b0; board_in = 32'hFFFF_FFFF;
    tick(); tick();
    push("rst_board", 0, 0); push("rst_mask", 1, 0); push("rst_lock", 2, 0);
    push("rst_next", 3, 0);  push("rst_over", 4, 0);
    drain();
    start = 1'b0; move_left = 1'b0; soft_drop = 1'b0; board_in = 32'h0;

    // Gravity timing on a type-10 piece over an empty board.
    reach_type10();
    load_after_lock(32'h0000_0066, 1'b0);
    push("load66_mask", 1, 32'h0000_0066);
    push("load66_board", 0, 32'h0000_0066);
    drain();
    for (int i = 0; i < DROP_DIV; i++) tick();
    push("grav_first_step", 1, 32'h0000_0660);
    drain();
    for (int i = 0; i < 5 * DROP_DIV; i++) tick();
    push("grav_bottom", 1, 32'h6600_0000);
    push("grav_no_lock_yet", 2, 0);
    drain();
    for (int i = 0; i < DROP_DIV - 1; i++) tick();
    push("grav_pre_lock", 2, 0);
    drain();
    tick();
    push("grav_lock", 2, 1);
    push("grav_lock_board", 0, 32'h6600_0000);
    push("grav_lock_next", 3, 32'd1);
    drain();

    // Lateral moves from the move table.
    reach_type10();
    load_after_lock(32'h0000_0066, 1'b0);
    for (int i = 0; i < 6; i++) begin
      move_left  = vt[i].ml;
      move_right = vt[i].mr;
      push($sformatf("move_vec%0d", i), 1, vt[i].exp_mask);
      tick();
      drain();
    end
    move_left = 1'b0; move_right = 1'b0;

    // Landing on a locked cell.
    reach_type10();
    load_after_lock(32'h0200_0066, 1'b0);
    push("coll_load_mask", 1, 32'h0000_0066);
    drain();
    soft_drop = 1'b1;
    wait_lock(20);
    soft_drop = 1'b0;
    push("coll_lock_board", 0, 32'h0266_0000);
    push("coll_lock_mask", 1, 32'h0066_0000);
    drain();

    // Spawn collision leads to sticky game over.
    reach_type10();
    load_after_lock(32'h0000_0066, 1'b1);
    push("over_flag", 4, 1);
    drain();
    locks = 0;
    for (int i = 0; i < 100; i++) begin
      start = (i == 10);
      tick();
      if (lock_valid) locks++;
    end
    start = 1'b0;
    compare("over_no_locks", locks, 0);
    push("over_sticky", 4, 1);
    push("over_board_held", 0, 32'h0000_0066);
    drain();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    push("over_cleared", 4, 0);
    drain();

    // Restart mid-fall with soft_drop held.
    reach_type10();
    load_after_lock(32'h0000_0066, 1'b0);
    tick(); tick(); tick();
    soft_drop = 1'b1;
    restart   = 1'b1;
    tick();
    push("midrst_board", 0, 0); push("midrst_mask", 1, 0); push("midrst_lock", 2, 0);
    push("midrst_next", 3, 0);  push("midrst_over", 4, 0);
    drain();
    restart = 1'b0; soft_drop = 1'b0;
    tick();
    push("midrst_idle_hold", 2, 0);
    drain();
    start = 1'b1;
    tick();
    start = 1'b0;
    push("midrst_lfsr_reseed", 3, 32'd3);
    push("midrst_start_lock", 2, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
